// File: rtl/control_pkg.sv
// Shared constants and helpers for the symbol-rate strobe generator.
//   NOS_DEFAULT   : default oversampling factor (clocks per symbol)
//   PHASE_DEFAULT : default counter value that fires the strobe
//   clog2()       : counter width for a modulo-N count, never below 1 bit
package control_pkg;

    localparam int unsigned NOS_DEFAULT   = 4;
    localparam int unsigned PHASE_DEFAULT = 0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/control_mod_counter.sv
// Modulo-N up counter with hold-on-disable and asynchronous clear.
//   clock    : rising-edge clock
//   i_reset  : asynchronous active-high clear to 0
//   i_enable : advance one step per edge when high, hold when low
//   o_count  : current count, 0..N-1
module mod_counter
    import control_pkg::*;
#(
    parameter int unsigned N = NOS_DEFAULT
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    output logic [clog2(N)-1:0] o_count
);

    localparam int unsigned W = clog2(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_enable) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/control.sv
// Symbol-rate sampling strobe: counts NOS clocks per symbol and emits a
// registered one-clock strobe each time the count passes PHASE.
//   clock    : rising-edge clock
//   i_reset  : asynchronous active-high reset (clears phase and strobe)
//   i_enable : advance enable; strobe is suppressed while low
//   o_valid  : registered strobe, high one clock in every NOS enabled clocks
module control
    import control_pkg::*;
#(
    parameter int unsigned NOS   = NOS_DEFAULT,
    parameter int unsigned PHASE = PHASE_DEFAULT
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_enable,
    output logic o_valid
);

    localparam int unsigned CW = clog2(NOS);
    localparam logic [CW-1:0] PHASE_C = CW'(PHASE);

    if (NOS < 2 || NOS > 256) begin : g_bad_nos
        $fatal(1, "control: NOS out of range 2..256");
    end
    if (PHASE >= NOS) begin : g_bad_phase
        $fatal(1, "control: PHASE out of range 0..NOS-1");
    end

    logic [CW-1:0] cnt;
    logic          valid_q;
    logic          valid_d;

    mod_counter #(
        .N (NOS)
    ) u_counter (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .o_count  (cnt)
    );

    // Decode on the pre-edge count; gated by enable so a held count that
    // happens to equal PHASE never strobes while disabled.
    always_comb begin
        valid_d = i_enable && (cnt == PHASE_C);
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign o_valid = valid_q;

endmodule

// File: tb/tb_control.sv
module tb_control;

    logic clock;
    logic i_reset;
    logic i_enable;
    logic v4, v8, v2;

    int errors = 0;
    int checks = 0;

    control #(.NOS(4), .PHASE(0)) u4 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .o_valid(v4));
    control #(.NOS(8), .PHASE(5)) u8 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .o_valid(v8));
    control #(.NOS(2), .PHASE(0)) u2 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .o_valid(v2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int pulses;
        int last8;
        // Pause scenario expectations (hand-derived, one entry per edge):
        // 2 enabled, 3 disabled, 4 enabled.
        logic pen  [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        logic pe4  [9] = '{1, 0, 0, 0, 0, 0, 0, 1, 0};
        logic pe8  [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        logic pe2  [9] = '{1, 0, 0, 0, 0, 1, 0, 1, 0};
        logic [1:0] pc4 [9] = '{1, 2, 2, 2, 2, 3, 0, 1, 2};

        i_reset  = 1'b1;
        i_enable = 1'b0;
        #2;
        check("reset_v4", {31'd0, v4}, 0);
        check("reset_cnt4", {30'd0, u4.cnt}, 0);
        check("reset_v8", {31'd0, v8}, 0);

        // Reset dominates enable.
        i_enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check("rst_hold_v4", {31'd0, v4}, 0);
            check("rst_hold_v8", {31'd0, v8}, 0);
            check("rst_hold_v2", {31'd0, v2}, 0);
            check("rst_hold_cnt4", {30'd0, u4.cnt}, 0);
        end

        // Free-running: edge k sees pre-edge count (k-1) mod NOS.
        i_reset = 1'b0;
        pulses = 0;
        last8  = -1;
        for (int k = 1; k <= 24; k++) begin
            step();
            check("run_v4", {31'd0, v4}, ((k - 1) % 4 == 0) ? 1 : 0);
            check("run_v8", {31'd0, v8}, ((k - 1) % 8 == 5) ? 1 : 0);
            check("run_v2", {31'd0, v2}, ((k - 1) % 2 == 0) ? 1 : 0);
            if (k <= 20 && v4) pulses++;
            if (v8) begin
                if (last8 >= 0) check("v8_spacing", k - last8, 8);
                last8 = k;
            end
        end
        check("v4_pulses_20", pulses, 5);
        check("v8_last_edge", last8, 22);

        // Pause and resume from the held count.
        i_reset = 1'b1;
        #1;
        i_reset = 1'b0;
        for (int k = 0; k < 9; k++) begin
            i_enable = pen[k];
            step();
            check("pause_v4", {31'd0, v4}, {31'd0, pe4[k]});
            check("pause_v8", {31'd0, v8}, {31'd0, pe8[k]});
            check("pause_v2", {31'd0, v2}, {31'd0, pe2[k]});
            check("pause_cnt4", {30'd0, u4.cnt}, {30'd0, pc4[k]});
        end

        // Asynchronous reset between edges: u4 at cnt=2, u8 strobing.
        i_reset = 1'b1;
        #1;
        i_reset = 1'b0;
        i_enable = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check("pre_cnt4", {30'd0, u4.cnt}, 2);
        check("pre_v8", {31'd0, v8}, 1);
        #1;
        i_reset = 1'b1;
        #1;
        check("async_cnt4", {30'd0, u4.cnt}, 0);
        check("async_v8", {31'd0, v8}, 0);
        check("async_cnt8", {29'd0, u8.cnt}, 0);
        #1;
        i_reset = 1'b0;
        step();
        check("post_rst_v4", {31'd0, v4}, 1);
        check("post_rst_v2", {31'd0, v2}, 1);
        check("post_rst_v8", {31'd0, v8}, 0);
        check("post_rst_cnt4", {30'd0, u4.cnt}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
